// File: rtl/frac_op_sched_pkg.sv
// Shared constants, FSM encoding and round-robin helper for the fractional-operator scheduler.
package frac_sched_pkg;

  localparam int ALPHA_DEF     = 8388608;   // 0.5 in Q8.24
  localparam int STEP_BETA_DEF = 16861102;
  localparam int OUT_SCALE_DEF = 100;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CHW   = 2;
  localparam int unsigned QW    = 32;
  localparam int unsigned QFRAC = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_MULA,
    S_MULB,
    S_SCALE
  } state_t;

  // First requesting channel after 'last', wrapping modulo NCH.
  function automatic logic [CHW-1:0] rr_pick(input logic [NCH-1:0] req,
                                             input logic [CHW-1:0] last);
    logic [CHW-1:0] idx;
    rr_pick = last;
    for (int unsigned i = NCH; i >= 1; i--) begin
      idx = last + CHW'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/frac_op_sched_if.sv
// Request/sample/result bundle between requesters and the scheduler.
interface frac_op_sched_if
  import frac_sched_pkg::*;
  ();

  logic [NCH-1:0]    Req_i;
  logic [NCH*QW-1:0] Signal_i;
  logic              Clr_i;
  logic [NCH-1:0]    Ack_o;
  logic [QW-1:0]     Output_o;
  logic [CHW-1:0]    OutCh_o;
  logic              OutValid_o;
  logic              Busy_o;

  modport master (
    output Req_i, Signal_i, Clr_i,
    input  Ack_o, Output_o, OutCh_o, OutValid_o, Busy_o
  );

  modport slave (
    input  Req_i, Signal_i, Clr_i,
    output Ack_o, Output_o, OutCh_o, OutValid_o, Busy_o
  );

endinterface

// File: rtl/frac_mul_q24.sv
// Signed 32x32 multiplier returning the full 64-bit product.
module frac_mul_q24 (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  output logic signed [63:0] p_o
);

  assign p_o = 64'(a_i) * 64'(b_i);

endmodule

// File: rtl/frac_op_sched.sv
// Four-channel fractional-order operator sharing one multiplier through a 5-state schedule.
module frac_op_sched
  import frac_sched_pkg::*;
#(
  parameter int ALPHA     = ALPHA_DEF,
  parameter int STEP_BETA = STEP_BETA_DEF,
  parameter int OUT_SCALE = OUT_SCALE_DEF
) (
  input  logic             clk_100HZ,
  input  logic             Rst_n,
  frac_op_sched_if.slave   bus
);

  localparam logic signed [QW-1:0] ALPHA_Q = ALPHA;
  localparam logic signed [QW-1:0] STEP_Q  = STEP_BETA;
  localparam logic signed [QW-1:0] SCALE_Q = OUT_SCALE;

  state_t state_q, state_d;

  logic signed [QW-1:0] prev_q [NCH];
  logic signed [QW-1:0] x_q;
  logic signed [QW-1:0] acc_q;
  logic [CHW-1:0]       ch_q;
  logic [CHW-1:0]       last_q;
  logic [NCH-1:0]       ack_q;
  logic [QW-1:0]        out_q;
  logic [CHW-1:0]       outch_q;
  logic                 valid_q;

  logic [CHW-1:0]       grant;
  logic signed [QW-1:0] sel_x;
  logic signed [QW-1:0] mul_b;
  logic signed [63:0]   product;
  logic                 unused_prod_hi;

  assign grant = rr_pick(bus.Req_i, last_q);
  assign sel_x = bus.Signal_i[grant*QW +: QW];

  // acc_q carries d, then t, then v through the three multiply stages.
  always_comb begin
    mul_b = '0;
    unique case (state_q)
      S_MULA:  mul_b = ALPHA_Q;
      S_MULB:  mul_b = STEP_Q;
      S_SCALE: mul_b = SCALE_Q;
      default: mul_b = '0;
    endcase
  end

  frac_mul_q24 u_mul (
    .a_i (acc_q),
    .b_i (mul_b),
    .p_o (product)
  );

  assign unused_prod_hi = ^product[63:56];

  always_comb begin
    state_d = state_q;
    if (bus.Clr_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (|bus.Req_i) state_d = S_DIFF;
        S_DIFF:  state_d = S_MULA;
        S_MULA:  state_d = S_MULB;
        S_MULB:  state_d = S_SCALE;
        S_SCALE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100HZ or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_100HZ or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned k = 0; k < NCH; k++) prev_q[k] <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      ch_q    <= '0;
      last_q  <= CHW'(NCH - 1);
      ack_q   <= '0;
      out_q   <= '0;
      outch_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.Clr_i) begin
      for (int unsigned k = 0; k < NCH; k++) prev_q[k] <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|bus.Req_i) begin
            x_q    <= sel_x;
            ch_q   <= grant;
            last_q <= grant;
            ack_q  <= NCH'(1) << grant;
          end
        end
        S_DIFF:  acc_q <= x_q - prev_q[ch_q];
        S_MULA:  acc_q <= product[55:24] + x_q;
        S_MULB:  acc_q <= product[55:24] - x_q;
        S_SCALE: begin
          out_q        <= product[31:0];
          outch_q      <= ch_q;
          prev_q[ch_q] <= x_q;
          valid_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Ack_o      = ack_q;
  assign bus.Output_o   = out_q;
  assign bus.OutCh_o    = outch_q;
  assign bus.OutValid_o = valid_q;
  assign bus.Busy_o     = (state_q != S_IDLE);

endmodule

// File: doc/frac_op_sched.md
FRAC_OP_SCHED -- requirements
Module: frac_op_sched

Interface
REQ-001 Parameter ALPHA, default 8388608, fractional order alpha in Q8.24 (0.5).
REQ-002 Parameter STEP_BETA, default 16861102, combined step/beta coefficient in Q8.24.
REQ-003 Parameter OUT_SCALE, default 100, integer output gain (1/step).
REQ-004 clk_100HZ  input  1  sole clock, all state on rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Req_i  input  4  per-channel level request, bit k = channel k has a sample pending.
REQ-007 Signal_i  input  128  packed samples, channel k at [32k+31:32k], signed Q8.24.
REQ-008 Clr_i  input  1  synchronous soft clear of all channel history.
REQ-009 Ack_o  output  4  one-hot one-cycle pulse, sample of that channel captured.
REQ-010 Output_o  output  32  signed result of last completed computation.
REQ-011 OutCh_o  output  2  channel index belonging to Output_o.
REQ-012 OutValid_o  output  1  one-cycle pulse, Output_o/OutCh_o newly updated.
REQ-013 Busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 Block SHALL time-share one fractional-operator datapath (single signed 32x32 multiplier) among 4 channels, each with its own 32-bit previous-sample register prev[k].
REQ-015 FSM states IDLE, DIFF, MULA, MULB, SCALE; IDLE->DIFF on any Req_i bit set, DIFF->MULA->MULB->SCALE->IDLE unconditionally.
REQ-016 On IDLE->DIFF edge: grant channel g by round-robin, latch x=Signal_i slice g, ch=g, pulse Ack_o[g] in the following cycle.
REQ-017 Round-robin: search starts at last-granted+1 mod 4; last-granted resets to 3 so channel 0 wins first.
REQ-018 DIFF: d = x - prev[ch], 32-bit wrap.
REQ-019 MULA: t = (d*ALPHA)[55:24] + x.
REQ-020 MULB: v = (t*STEP_BETA)[55:24] - x.
REQ-021 SCALE: Output_o = (v*OUT_SCALE)[31:0]; OutCh_o = ch; prev[ch] = x; OutValid_o high the next cycle only.
REQ-022 All arithmetic two's complement, 64-bit product, no saturation or rounding (truncation).
REQ-023 Latency: capture edge to OutValid_o = 4 cycles; throughput one sample per 5 cycles.
REQ-024 Req_i changes outside IDLE SHALL be ignored; requester holds Req_i until its Ack_o.
REQ-025 Clr_i high SHALL zero all prev[k], return FSM to IDLE, suppress any pending OutValid_o; Output_o retained; Clr_i has priority over a simultaneous request.
REQ-026 Only one multiplication SHALL be issued per cycle.

Reset
REQ-027 Rst_n low SHALL asynchronously force: state IDLE, prev[k]=0, last-granted=3, Ack_o=0, Output_o=0, OutCh_o=0, OutValid_o=0, Busy_o=0.
REQ-028 Reset mid-operation SHALL abort the computation with no OutValid_o and no prev update.
REQ-029 First request is served on the first rising edge after Rst_n deasserts.

Structure
REQ-030 Package frac_sched_pkg holds ALPHA/STEP_BETA/OUT_SCALE defaults, NCH=4, Q-format width constants (32, frac 24) and the FSM state encoding.
REQ-031 Sub-module frac_mul_q24: signed 32x32 multiply returning full 64-bit product, instantiated once.

Verification
REQ-032 Ch0 alone, prev=0, x=16777216 -> Ack_o=0001, 4 cycles later OutValid_o, Output_o=851443700, OutCh_o=0.
REQ-033 Ch0 again x=16777216 -> Output_o=8388600 (d=0 path).
REQ-034 Req_i=1111 held, re-asserted after each ack -> grant order 0,1,2,3,0; Ack_o spacing 5 cycles.
REQ-035 Rst_n low during MULA -> no OutValid_o, all outputs 0; ch0 x=16777216 after release -> 851443700.
REQ-036 Clr_i during MULB with Req_i=0010 -> no OutValid_o, FSM IDLE; next grant ch1 uses prev=0.
REQ-037 x=-16777216 on fresh channel -> Output_o=-851443700 (sign/truncation check).
